controllo_pila: RTL and testbench

Sequencing controller for the dual-port stack memory (N words × M bits, port 1 read/write, port 2 read-only, combinational read delay). It sits between the stack unit's operation source and the memory:
- accepts one stack operation at a time over a req/ack handshake;
- maintains the stack pointer/count;
- drives the memory addresses, write data and write enable;
- samples read data after a programmable wait;
- flags overflow and underflow.

---
 rtl/controllo_pila_if.sv | 36 +++
 rtl/controllo_pila.sv | 173 +++++++++++++++++
 tb/tb_controllo_pila.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controllo_pila_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : controllo_pila_if                                       |
// | Desc     : operation-side handshake bundle of the stack controller |
// |            (request, operation, data, completion and status)       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface controllo_pila_if #(
  parameter int M        = 32,
  parameter int IND_SIZE = 10
);
  logic                req;
  logic [1:0]          op;
  logic [M-1:0]        din;
  logic                ack;
  logic                errore;
  logic [M-1:0]        dout;
  logic [M-1:0]        dout2;
  logic                occupato;
  logic                vuota;
  logic                piena;
  logic [IND_SIZE:0]   cont;

  // operation source
  modport master (
    output req, op, din,
    input  ack, errore, dout, dout2, occupato, vuota, piena, cont
  );

  // stack controller
  modport slave (
    input  req, op, din,
    output ack, errore, dout, dout2, occupato, vuota, piena, cont
  );
endinterface
`default_nettype wire

// File: rtl/controllo_pila.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : controllo_pila                                          |
// | Desc     : sequencing controller for a dual-port stack memory:     |
// |            req/ack handshake, stack count, memory drive, delayed   |
// |            read sampling, overflow/underflow rejection.            |
// | Option   : define PILA_TOP2_EN to support TOP2 (op 11) and drive   |
// |            memory port 2; otherwise op 11 is always rejected.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module controllo_pila #(
  parameter int N        = 1024,
  parameter int M        = 32,
  parameter int IND_SIZE = $clog2(N),
  parameter int ATTESA   = 1
) (
  input  logic                clock,
  input  logic                reset,
  controllo_pila_if.slave     bus,
  output logic [IND_SIZE-1:0] mem_ind1,
  output logic [IND_SIZE-1:0] mem_ind2,
  output logic [M-1:0]        mem_in,
  output logic                mem_beta,
  input  logic [M-1:0]        mem_out1,
  input  logic [M-1:0]        mem_out2
);

  localparam int CW = (ATTESA > 0) ? $clog2(ATTESA + 1) : 1;
  localparam logic [IND_SIZE:0] PIENO = (IND_SIZE + 1)'(N);
  localparam logic [IND_SIZE:0] UNO   = (IND_SIZE + 1)'(1);
  localparam logic [IND_SIZE:0] DUE   = (IND_SIZE + 1)'(2);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_TOP  = 2'b10;
  localparam logic [1:0] OP_TOP2 = 2'b11;

  typedef enum logic [1:0] {
    RIPOSO    = 2'd0,
    ACCESSO   = 2'd1,
    ST_ATTESA = 2'd2,
    FINE      = 2'd3
  } stato_t;

  stato_t            stato, stato_next;
  logic [1:0]        op_q;
  logic [M-1:0]      din_q;
  logic              err_q;
  logic              err_new;
  logic [IND_SIZE:0] cont_q;
  logic [M-1:0]      dout_q;
  logic [CW-1:0]     cnt_q;
  logic              campiona;
  logic              scrivi;
  logic              attivo;
  logic [IND_SIZE-1:0] ind_m1;

  // Rejection decision for the operation currently presented at the input
  always_comb begin
    err_new = 1'b0;
    case (bus.op)
      OP_PUSH: err_new = (cont_q == PIENO);
      OP_POP:  err_new = (cont_q == '0);
      OP_TOP:  err_new = (cont_q == '0);
      default: begin
`ifdef PILA_TOP2_EN
        err_new = (cont_q < DUE);
`else
        err_new = 1'b1;
`endif
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) stato <= RIPOSO;
    else       stato <= stato_next;
  end

  // Next state plus the write and sample strobes
  always_comb begin
    stato_next = stato;
    campiona   = 1'b0;
    scrivi     = 1'b0;
    case (stato)
      RIPOSO: begin
        if (bus.req) stato_next = ACCESSO;
      end
      ACCESSO: begin
        if (op_q == OP_PUSH || err_q) begin
          scrivi     = (op_q == OP_PUSH) && !err_q;
          stato_next = FINE;
        end else if (ATTESA == 0) begin
          campiona   = 1'b1;
          stato_next = FINE;
        end else begin
          stato_next = ST_ATTESA;
        end
      end
      ST_ATTESA: begin
        // counter holds the cycles still to wait; the last one samples
        if (cnt_q <= CW'(1)) begin
          campiona   = 1'b1;
          stato_next = FINE;
        end
      end
      default: stato_next = RIPOSO;
    endcase
  end

  // Operation latch, wait counter, stack count and read-data registers
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q   <= OP_PUSH;
      din_q  <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      cont_q <= '0;
      dout_q <= '0;
    end else begin
      if (stato == RIPOSO && bus.req) begin
        op_q  <= bus.op;
        din_q <= bus.din;
        err_q <= err_new;
      end
      if (stato == ACCESSO)        cnt_q <= CW'(ATTESA);
      else if (stato == ST_ATTESA) cnt_q <= cnt_q - CW'(1);
      if (scrivi) cont_q <= cont_q + UNO;
      if (campiona) begin
        dout_q <= mem_out1;
        if (op_q == OP_POP) cont_q <= cont_q - UNO;
      end
    end
  end

  // Memory addressing is live only while a valid operation owns the memory
  assign attivo   = (stato == ACCESSO || stato == ST_ATTESA) && !err_q;
  assign ind_m1   = cont_q[IND_SIZE-1:0] - IND_SIZE'(1);
  assign mem_ind1 = !attivo ? '0 :
                    (op_q == OP_PUSH) ? cont_q[IND_SIZE-1:0] : ind_m1;
  assign mem_in   = (attivo && op_q == OP_PUSH) ? din_q : '0;
  assign mem_beta = scrivi;

`ifdef PILA_TOP2_EN
  logic [M-1:0] dout2_q;

  // Second-word register, loaded only by a completed TOP2
  always_ff @(posedge clock) begin
    if (reset)                           dout2_q <= '0;
    else if (campiona && op_q == OP_TOP2) dout2_q <= mem_out2;
  end

  assign mem_ind2  = (attivo && op_q == OP_TOP2) ?
                     cont_q[IND_SIZE-1:0] - IND_SIZE'(2) : '0;
  assign bus.dout2 = dout2_q;
`else
  logic unused_mem_out2;
  assign unused_mem_out2 = ^mem_out2;
  assign mem_ind2        = '0;
  assign bus.dout2       = '0;
`endif

  assign bus.ack      = (stato == FINE);
  assign bus.errore   = (stato == FINE) && err_q;
  assign bus.occupato = (stato != RIPOSO);
  assign bus.vuota    = (cont_q == '0);
  assign bus.piena    = (cont_q == PIENO);
  assign bus.cont     = cont_q;
  assign bus.dout     = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_controllo_pila.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_controllo_pila                                       |
// | Desc     : self-checking bench for controllo_pila with a queue-    |
// |            based stack model and a behavioural dual-port memory.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_controllo_pila;
  localparam int N   = 4;
  localparam int M   = 32;
  localparam int IND = 2;
  localparam int ATT = 2;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, TOP = 2'b10, TOP2 = 2'b11;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [IND-1:0] mem_ind1, mem_ind2;
  logic [M-1:0]   mem_in, mem_out1, mem_out2;
  logic           mem_beta;
  logic [M-1:0]   mem [0:N-1];

  controllo_pila_if #(.M(M), .IND_SIZE(IND)) bus ();

  controllo_pila #(.N(N), .M(M), .IND_SIZE(IND), .ATTESA(ATT)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .mem_ind1(mem_ind1), .mem_ind2(mem_ind2), .mem_in(mem_in),
    .mem_beta(mem_beta), .mem_out1(mem_out1), .mem_out2(mem_out2)
  );

  always #5 clock = ~clock;

  // stack memory: synchronous write, combinational read on both ports
  always @(posedge clock) if (mem_beta) mem[mem_ind1] <= mem_in;
  assign mem_out1 = mem[mem_ind1];
  assign mem_out2 = mem[mem_ind2];

  // reference model
  logic [M-1:0] pila [$];
  logic [M-1:0] m_dout, m_dout2;
  int checks = 0;
  int errors = 0;

  function automatic void modello(input logic [1:0] o, input logic [M-1:0] d,
                                  output bit e, output int lat);
    e = 1'b0;
    case (o)
      PUSH: if (pila.size() == N) e = 1'b1; else pila.push_back(d);
      POP:  if (pila.size() == 0) e = 1'b1; else m_dout = pila.pop_back();
      TOP:  if (pila.size() == 0) e = 1'b1; else m_dout = pila[pila.size()-1];
      default: begin
`ifdef PILA_TOP2_EN
        if (pila.size() < 2) e = 1'b1;
        else begin
          m_dout  = pila[pila.size()-1];
          m_dout2 = pila[pila.size()-2];
        end
`else
        e = 1'b1;
`endif
      end
    endcase
    lat = (e || o == PUSH) ? 2 : 2 + ATT;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b1;
    bus.req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pila.delete();
    m_dout  = '0;
    m_dout2 = '0;
  endtask

  // issue one operation and wait (bounded) for its ack; returns the number
  // of negedges from request to ack and whether mem_beta was seen high
  task automatic esegui(input logic [1:0] o, input logic [M-1:0] d,
                        output int lat, output bit sb);
    @(negedge clock);
    bus.req = 1'b1; bus.op = o; bus.din = d;
    lat = 0; sb = 1'b0;
    do begin
      @(negedge clock);
      lat++;
      if (mem_beta) sb = 1'b1;
      if (lat == 1) begin bus.op = 2'($urandom); bus.din = $urandom; end
    end while (bus.ack !== 1'b1 && lat < 40);
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; bus.req = 1'b0; bus.op = PUSH; bus.din = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.ack, bus.errore, bus.occupato, bus.vuota, bus.piena, mem_beta} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000100", {bus.ack, bus.errore, bus.occupato, bus.vuota, bus.piena, mem_beta});
    end
    checks++;
    if (bus.cont !== 3'd0 || bus.dout !== '0 || bus.dout2 !== '0) begin
      errors++;
      $display("FAIL reset_data: cont %0d dout %h dout2 %h expected 0 0 0", bus.cont, bus.dout, bus.dout2);
    end
    checks++;
    if (mem_ind1 !== '0 || mem_ind2 !== '0 || mem_in !== '0) begin
      errors++;
      $display("FAIL reset_mem: ind1 %0d ind2 %0d in %h expected 0 0 0", mem_ind1, mem_ind2, mem_in);
    end
    reset = 1'b0;
    pila.delete(); m_dout = '0; m_dout2 = '0;
  endtask

  task automatic test_push_basic();
    int lat, l_exp; bit sb, e_exp;
    logic [M-1:0] vals [2];
    vals[0] = 32'hA5; vals[1] = 32'h3C;
    for (int i = 0; i < 2; i++) begin
      modello(PUSH, vals[i], e_exp, l_exp);
      esegui(PUSH, vals[i], lat, sb);
      checks++;
      if (lat !== l_exp || bus.errore !== e_exp || sb !== 1'b1) begin
        errors++;
        $display("FAIL push%0d: lat %0d err %b wr %b expected lat %0d err %b wr 1", i, lat, bus.errore, sb, l_exp, e_exp);
      end
    end
    checks++;
    if (bus.cont !== 3'd2) begin errors++; $display("FAIL push_cont: got %0d expected 2", bus.cont); end
    @(negedge clock);
    checks++;
    if (bus.ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: ack %b one cycle after FINE expected 0", bus.ack); end
    checks++;
    if (mem[0] !== 32'hA5 || mem[1] !== 32'h3C) begin
      errors++;
      $display("FAIL push_mem: mem0 %h mem1 %h expected a5 3c", mem[0], mem[1]);
    end
  endtask

  task automatic test_top2();
    int lat, l_exp; bit sb, e_exp;
    modello(TOP2, '0, e_exp, l_exp);
    esegui(TOP2, '0, lat, sb);
    checks++;
    if (lat !== l_exp || bus.errore !== e_exp) begin
      errors++; $display("FAIL top2_ack: lat %0d err %b expected lat %0d err %b", lat, bus.errore, l_exp, e_exp);
    end
    checks++;
    if (bus.dout !== m_dout || bus.dout2 !== m_dout2 || bus.cont !== 3'd2) begin
      errors++;
      $display("FAIL top2_data: dout %h dout2 %h cont %0d expected %h %h 2", bus.dout, bus.dout2, bus.cont, m_dout, m_dout2);
    end
    modello(POP, '0, e_exp, l_exp);
    esegui(POP, '0, lat, sb);
    checks++;
    if (lat !== l_exp || bus.errore !== 1'b0 || bus.dout !== 32'h3C || bus.cont !== 3'd1 || sb !== 1'b0) begin
      errors++;
      $display("FAIL pop_after_top2: lat %0d err %b dout %h cont %0d wr %b expected lat %0d err 0 dout 3c cont 1 wr 0",
               lat, bus.errore, bus.dout, bus.cont, sb, l_exp);
    end
  endtask

  task automatic test_underflow();
    int lat, l_exp; bit sb, e_exp;
    logic [1:0] ops [3];
    ops[0] = POP; ops[1] = POP; ops[2] = TOP2;
    for (int i = 0; i < 3; i++) begin
      modello(ops[i], '0, e_exp, l_exp);
      esegui(ops[i], '0, lat, sb);
      checks++;
      if (lat !== l_exp || bus.errore !== e_exp || bus.dout !== m_dout || bus.cont !== 3'(pila.size()) || sb !== 1'b0) begin
        errors++;
        $display("FAIL underflow%0d: lat %0d err %b dout %h cont %0d wr %b expected lat %0d err %b dout %h cont %0d wr 0",
                 i, lat, bus.errore, bus.dout, bus.cont, sb, l_exp, e_exp, m_dout, pila.size());
      end
    end
    checks++;
    if (bus.vuota !== 1'b1 || bus.piena !== 1'b0) begin
      errors++; $display("FAIL underflow_flags: vuota %b piena %b expected 1 0", bus.vuota, bus.piena);
    end
  endtask

  task automatic test_overflow();
    int lat, l_exp; bit sb, e_exp;
    logic [M-1:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      modello(PUSH, d, e_exp, l_exp);
      esegui(PUSH, d, lat, sb);
      checks++;
      if (lat !== l_exp || bus.errore !== e_exp || sb !== !e_exp) begin
        errors++;
        $display("FAIL overflow_push%0d: lat %0d err %b wr %b expected lat %0d err %b wr %b", i, lat, bus.errore, sb, l_exp, e_exp, !e_exp);
      end
    end
    checks++;
    if (bus.piena !== 1'b1 || bus.cont !== 3'd4) begin
      errors++; $display("FAIL overflow_state: piena %b cont %0d expected 1 4", bus.piena, bus.cont);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== pila[i]) begin errors++; $display("FAIL overflow_mem%0d: got %h expected %h", i, mem[i], pila[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int t [3];
    int cyc, idx, l_exp;
    bit e_exp;
    logic [1:0]   ops [3];
    logic [M-1:0] ds  [3];
    do_reset();
    ops[0] = PUSH; ops[1] = PUSH; ops[2] = POP;
    ds[0] = $urandom; ds[1] = $urandom; ds[2] = $urandom;
    for (int i = 0; i < 3; i++) begin modello(ops[i], ds[i], e_exp, l_exp); t[i] = -1; end
    @(negedge clock);
    bus.req = 1'b1; bus.op = ops[0]; bus.din = ds[0];
    cyc = 0; idx = 0;
    while (idx < 3 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (bus.ack === 1'b1) begin
        t[idx] = cyc;
        idx++;
        if (idx < 3) begin bus.op = ops[idx]; bus.din = ds[idx]; end
        else bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    checks++;
    if (t[0] !== 2 || t[1] - t[0] !== 3 || t[2] - t[1] !== 3 + ATT) begin
      errors++;
      $display("FAIL b2b_spacing: acks at %0d %0d %0d expected 2 5 %0d", t[0], t[1], t[2], 5 + 3 + ATT);
    end
    checks++;
    if (bus.cont !== 3'd1 || bus.dout !== ds[1] || bus.dout !== m_dout) begin
      errors++; $display("FAIL b2b_result: cont %0d dout %h expected 1 %h", bus.cont, bus.dout, ds[1]);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit sb, seen_ack;
    esegui(PUSH, 32'h1234_5678, lat, sb);
    @(negedge clock);
    bus.req = 1'b1; bus.op = POP;
    @(negedge clock);
    bus.req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.occupato !== 1'b1 || bus.ack !== 1'b0) begin
      errors++; $display("FAIL midrst_wait: occupato %b ack %b expected 1 0", bus.occupato, bus.ack);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({bus.ack, bus.errore, bus.occupato, mem_beta} !== 4'b0000 || bus.cont !== 3'd0 || bus.dout !== '0 ||
        bus.dout2 !== '0 || mem_ind1 !== '0 || mem_ind2 !== '0 || mem_in !== '0) begin
      errors++;
      $display("FAIL midrst_values: ack %b err %b occ %b beta %b cont %0d dout %h ind1 %0d in %h expected all 0",
               bus.ack, bus.errore, bus.occupato, mem_beta, bus.cont, bus.dout, mem_ind1, mem_in);
    end
    seen_ack = 1'b0;
    repeat (6) begin @(negedge clock); if (bus.ack !== 1'b0) seen_ack = 1'b1; end
    checks++;
    if (seen_ack) begin errors++; $display("FAIL midrst_noack: ack seen 1 expected 0"); end
    pila.delete(); m_dout = '0; m_dout2 = '0;
  endtask

  task automatic test_random();
    int lat, l_exp; bit sb, e_exp;
    logic [1:0]   o;
    logic [M-1:0] d;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      d = $urandom;
      modello(o, d, e_exp, l_exp);
      esegui(o, d, lat, sb);
      checks++;
      if (lat !== l_exp || bus.errore !== e_exp || sb !== (o == PUSH && !e_exp) ||
          bus.cont !== 3'(pila.size()) || bus.dout !== m_dout || bus.dout2 !== m_dout2 ||
          bus.vuota !== (pila.size() == 0) || bus.piena !== (pila.size() == N)) begin
        errors++;
        $display("FAIL random%0d op %0d: lat %0d err %b wr %b cont %0d dout %h dout2 %h expected lat %0d err %b cont %0d dout %h dout2 %h",
                 i, o, lat, bus.errore, sb, bus.cont, bus.dout, bus.dout2, l_exp, e_exp, pila.size(), m_dout, m_dout2);
      end
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.op = PUSH; bus.din = '0;
    m_dout = '0; m_dout2 = '0;
    test_reset();
    test_push_basic();
    test_top2();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
